// File: rtl/tdc_sequencer_if.sv
// tdc_sequencer_if: start/launch/tap/result handshake bundle between the TDC sequencer and its consumer
interface tdc_sequencer_if #(
    parameter int LENGTH   = 128,
    parameter int AVG_LOG2 = 3
);
    localparam int CW = $clog2(LENGTH + 1);
    logic                   iSTART;
    logic                   oBUSY;
    logic                   oLAUNCH;
    logic [LENGTH-1:0]      iTAPS;
    logic [CW+AVG_LOG2-1:0] oRESULT;
    logic                   oOVF;
    logic                   oVALID;
    logic                   iREADY;
    modport master (input iSTART, iTAPS, iREADY, output oBUSY, oLAUNCH, oRESULT, oOVF, oVALID);
    modport slave (output iSTART, iTAPS, iREADY, input oBUSY, oLAUNCH, oRESULT, oOVF, oVALID);
endinterface

// File: rtl/tdc_sequencer.sv
// tdc_sequencer: launches delay-line edges, encodes tap snapshots and averages 2**AVG_LOG2 samples.
// Optional macro TDC_BUBBLE_FILTER_EN inserts a 3-tap majority bubble filter before the encoder.
module tdc_sequencer #(
    parameter int LENGTH     = 128,
    parameter int AVG_LOG2   = 3,
    parameter int SAMPLE_DLY = 1,
    parameter int RELAX_CYC  = 4
) (
    input logic             iCLK,
    input logic             iRESETn,
    tdc_sequencer_if.master bus
);
    localparam int CW = $clog2(LENGTH + 1);
    localparam int AW = CW + AVG_LOG2;
    localparam int SW = AVG_LOG2 + 1;
    localparam logic [CW-1:0] FULL     = CW'(LENGTH);
    localparam logic [SW-1:0] NSMP     = SW'(1) << AVG_LOG2;
    localparam logic [7:0]    LAUNCH_T = 8'(SAMPLE_DLY - 1);
    localparam logic [7:0]    RELAX_T  = 8'(RELAX_CYC - 1);

    typedef enum logic [2:0] {IDLE, LAUNCH, CAPTURE, FILTER, ENCODE, ACCUM, RELAX, DONE} state_t;

    state_t            state_q, state_d;
    logic [7:0]        tmr_q, tmr_d;
    logic [SW-1:0]     smp_q, smp_d;
    logic [LENGTH-1:0] snap_q, snap_d;
    logic [LENGTH-1:0] filt_q, filt_d;
    logic [LENGTH-1:0] enc_src;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [AW-1:0]     result_q, result_d;
    logic              ovf_q, ovf_d;
    logic              busy_q, busy_d;
    logic              launch_q, launch_d;
    logic              valid_q, valid_d;

    // Thermometer position: index of the first 0 counted from tap 0, LENGTH when every tap is set.
    function automatic logic [CW-1:0] lead_ones(input logic [LENGTH-1:0] v);
        logic [CW-1:0] n;
        n = FULL;
        for (int i = LENGTH - 1; i >= 0; i--)
            if (!v[i]) n = CW'(i);
        return n;
    endfunction

`ifdef TDC_BUBBLE_FILTER_EN
    // Majority of each tap with its neighbours; the end taps are replicated outward.
    function automatic logic [LENGTH-1:0] maj3(input logic [LENGTH-1:0] s);
        logic [LENGTH+1:0] e;
        logic [LENGTH-1:0] f;
        e = {s[LENGTH-1], s, s[0]};
        for (int i = 0; i < LENGTH; i++)
            f[i] = (e[i] & e[i+1]) | (e[i] & e[i+2]) | (e[i+1] & e[i+2]);
        return f;
    endfunction
    assign enc_src = filt_q;
`else
    assign enc_src = snap_q;
`endif

    // Next-state and datapath updates; outputs are derived from the next state so they stay registered.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        smp_d   = smp_q;
        snap_d  = snap_q;
        filt_d  = filt_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (bus.iSTART) begin
                acc_d   = '0;
                ovf_d   = 1'b0;
                smp_d   = '0;
                tmr_d   = LAUNCH_T;
                state_d = LAUNCH;
            end
            LAUNCH: begin
                tmr_d   = (tmr_q == '0) ? tmr_q : tmr_q - 8'd1;
                state_d = (tmr_q == '0) ? CAPTURE : LAUNCH;
            end
            CAPTURE: begin
                snap_d = bus.iTAPS;
`ifdef TDC_BUBBLE_FILTER_EN
                state_d = FILTER;
`else
                state_d = ENCODE;
`endif
            end
`ifdef TDC_BUBBLE_FILTER_EN
            FILTER: begin
                filt_d  = maj3(snap_q);
                state_d = ENCODE;
            end
`endif
            ENCODE: begin
                cnt_d   = lead_ones(enc_src);
                ovf_d   = ovf_q | (cnt_d == FULL);
                state_d = ACCUM;
            end
            ACCUM: begin
                acc_d   = acc_q + AW'(cnt_q);
                smp_d   = smp_q + 1'b1;
                tmr_d   = RELAX_T;
                state_d = RELAX;
            end
            RELAX: begin
                tmr_d   = (tmr_q == '0) ? LAUNCH_T : tmr_q - 8'd1;
                state_d = (tmr_q != '0) ? RELAX : (smp_q == NSMP) ? DONE : LAUNCH;
            end
            DONE: state_d = bus.iREADY ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
        busy_d   = state_d != IDLE;
        launch_d = state_d inside {LAUNCH, CAPTURE, FILTER, ENCODE};
        valid_d  = state_d == DONE;
        result_d = (state_q == RELAX && state_d == DONE) ? acc_q : result_q;
    end

    // Single state register for the whole sequencer; reset abandons any measurement in flight.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q  <= IDLE;
            tmr_q    <= '0;
            smp_q    <= '0;
            snap_q   <= '0;
            filt_q   <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            launch_q <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tmr_q    <= tmr_d;
            smp_q    <= smp_d;
            snap_q   <= snap_d;
            filt_q   <= filt_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            launch_q <= launch_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.oBUSY   = busy_q;
    assign bus.oLAUNCH = launch_q;
    assign bus.oRESULT = result_q;
    assign bus.oOVF    = ovf_q;
    assign bus.oVALID  = valid_q;
endmodule

// File: tb/tb_tdc_sequencer.sv
// tb_tdc_sequencer: scoreboard bench for tdc_sequencer, one instance averaging 8 samples and one taking 1.
module tb_tdc_sequencer;
    localparam int SD = 1;
    localparam int RC = 4;
`ifdef TDC_BUBBLE_FILTER_EN
    localparam int FX  = 1;
    localparam int BUB = 16;
`else
    localparam int FX  = 0;
    localparam int BUB = 3;
`endif
    localparam int P = SD + 3 + RC + FX;

    typedef struct {
        int res;
        int ovf;
        int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tdc_sequencer_if #(.LENGTH(128), .AVG_LOG2(3)) a_if ();
    tdc_sequencer_if #(.LENGTH(128), .AVG_LOG2(0)) b_if ();

    tdc_sequencer #(.LENGTH(128), .AVG_LOG2(3), .SAMPLE_DLY(SD), .RELAX_CYC(RC)) dut_a (
        .iCLK(clk), .iRESETn(rst_n), .bus(a_if));
    tdc_sequencer #(.LENGTH(128), .AVG_LOG2(0), .SAMPLE_DLY(SD), .RELAX_CYC(RC)) dut_b (
        .iCLK(clk), .iRESETn(rst_n), .bus(b_if));

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int start_a = 0;
    int start_b = 0;
    exp_t qa[$];
    exp_t qb[$];

    int sidx = 0;
    int special_idx = 0;
    logic [127:0] taps_norm = '0;
    logic [127:0] taps_special = '0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Per-sample tap pattern for instance A, switched on every launch edge.
    always @(posedge a_if.oLAUNCH) begin
        sidx++;
        a_if.iTAPS = (sidx == special_idx) ? taps_special : taps_norm;
    end

    // Monitor A: pop and compare on every new result presentation.
    always @(negedge clk) begin : mon_a
        logic prev;
        exp_t e;
        if (a_if.oVALID === 1'b1 && prev !== 1'b1) begin
            check("a_sb_nonempty", int'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                e = qa.pop_front();
                check("a_result", int'(a_if.oRESULT), e.res);
                check("a_ovf", int'(a_if.oOVF), e.ovf);
                check("a_latency", cyc - start_a, e.lat);
            end
        end
        prev = a_if.oVALID;
    end

    // Monitor B.
    always @(negedge clk) begin : mon_b
        logic prev;
        exp_t e;
        if (b_if.oVALID === 1'b1 && prev !== 1'b1) begin
            check("b_sb_nonempty", int'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                e = qb.pop_front();
                check("b_result", int'(b_if.oRESULT), e.res);
                check("b_ovf", int'(b_if.oOVF), e.ovf);
                check("b_latency", cyc - start_b, e.lat);
            end
        end
        prev = b_if.oVALID;
    end

    task automatic start_run(input bit b);
        @(negedge clk);
        if (b) begin
            b_if.iSTART = 1'b1;
            start_b = cyc;
        end else begin
            sidx = 0;
            a_if.iSTART = 1'b1;
            start_a = cyc;
        end
        @(negedge clk);
        a_if.iSTART = 1'b0;
        b_if.iSTART = 1'b0;
    endtask

    task automatic wait_idle(input bit b, input string name);
        int n;
        n = 0;
        while ((b ? b_if.oBUSY : a_if.oBUSY) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(b ? b_if.oBUSY : a_if.oBUSY), 0);
    endtask

    initial begin
        int hi, lo, n, bad_v, bad_r, bad_b;
        a_if.iSTART = 1'b0;
        a_if.iREADY = 1'b1;
        a_if.iTAPS = '0;
        b_if.iSTART = 1'b0;
        b_if.iREADY = 1'b1;
        b_if.iTAPS = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", int'(a_if.oBUSY), 0);
        check("rst_launch", int'(a_if.oLAUNCH), 0);
        check("rst_result", int'(a_if.oRESULT), 0);
        check("rst_ovf", int'(a_if.oOVF), 0);
        check("rst_valid", int'(a_if.oVALID), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Asynchronous reset while launching
        taps_norm = 128'hFF;
        start_run(0);
        check("t1_launch_hi", int'(a_if.oLAUNCH), 1);
        check("t1_busy_hi", int'(a_if.oBUSY), 1);
        #1 rst_n = 1'b0;
        #1;
        check("t1_async_busy", int'(a_if.oBUSY), 0);
        check("t1_async_launch", int'(a_if.oLAUNCH), 0);
        check("t1_async_valid", int'(a_if.oVALID), 0);
        check("t1_async_result", int'(a_if.oRESULT), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t1_stays_idle", int'(a_if.oBUSY), 0);

        // 40 leading ones every sample, plus launch pulse widths
        taps_norm = {88'b0, {40{1'b1}}};
        special_idx = 0;
        qa.push_back('{res: 320, ovf: 0, lat: 1 + 8 * P});
        start_run(0);
        hi = 0;
        while (a_if.oLAUNCH && hi < 100) begin
            hi++;
            @(negedge clk);
        end
        lo = 0;
        while (!a_if.oLAUNCH && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check("t6_launch_high_cycles", hi, SD + 2 + FX);
        check("t6_launch_low_cycles", lo, RC + 1);
        wait_idle(0, "t2_done_timeout");

        // Saturated snapshot on sample 5 only
        taps_norm = {118'b0, {10{1'b1}}};
        taps_special = '1;
        special_idx = 5;
        qa.push_back('{res: 7 * 10 + 128, ovf: 1, lat: 1 + 8 * P});
        start_run(0);
        wait_idle(0, "t3_done_timeout");
        special_idx = 0;

        // Single-zero bubble at tap 3 within 16 low ones
        taps_norm = 128'hFFF7;
        qa.push_back('{res: 8 * BUB, ovf: 0, lat: 1 + 8 * P});
        start_run(0);
        wait_idle(0, "t4_done_timeout");

        // Back-pressure: result held through 20 stalled cycles, iSTART in DONE ignored
        taps_norm = 128'h7F;
        a_if.iREADY = 1'b0;
        qa.push_back('{res: 56, ovf: 0, lat: 1 + 8 * P});
        start_run(0);
        n = 0;
        while (!a_if.oVALID && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t5_valid_seen", int'(a_if.oVALID), 1);
        bad_v = 0;
        bad_r = 0;
        for (int i = 0; i < 20; i++) begin
            a_if.iSTART = (i == 10);
            @(negedge clk);
            if (a_if.oVALID !== 1'b1) bad_v++;
            if (a_if.oRESULT !== 11'd56) bad_r++;
        end
        a_if.iSTART = 1'b0;
        check("t5_valid_stable", bad_v, 0);
        check("t5_result_stable", bad_r, 0);
        a_if.iREADY = 1'b1;
        @(negedge clk);
        check("t5_valid_dropped", int'(a_if.oVALID), 0);
        check("t5_idle_after_accept", int'(a_if.oBUSY), 0);
        check("t5_result_held", int'(a_if.oRESULT), 56);
        bad_b = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_if.oBUSY !== 1'b0) bad_b++;
        end
        check("t5_no_queued_start", bad_b, 0);

        // Single-sample instance: empty line, then 6 ones
        b_if.iTAPS = '0;
        qb.push_back('{res: 0, ovf: 0, lat: 1 + P});
        start_run(1);
        wait_idle(1, "t6_done_timeout");
        b_if.iTAPS = 128'h3F;
        qb.push_back('{res: 6, ovf: 0, lat: 1 + P});
        start_run(1);
        wait_idle(1, "t6b_done_timeout");

        repeat (3) @(negedge clk);
        check("a_sb_drained", qa.size(), 0);
        check("b_sb_drained", qb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
